// File: rtl/wb_arbiter_pkg.sv
// Shared core constants: register-file geometry and writeback requester indices.
package wb_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LD  = 1;

    typedef enum logic {
        ReqAlu = 1'b0,
        ReqLd  = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: valid pair plus last-winner pointer gives a one-hot grant.
module rr_arb2
    import wb_arbiter_pkg::*;
(
    input  logic       alu_valid,
    input  logic       ld_valid,
    input  logic       last_ld,
    input  logic       block,
    output logic [1:0] gnt
);

    req_e winner;

    always_comb begin
        gnt    = 2'b00;
        winner = ReqAlu;
        if (alu_valid && ld_valid) begin
            // On a conflict the requester that did not win last time goes first.
            winner = last_ld ? ReqAlu : ReqLd;
        end else if (ld_valid) begin
            winner = ReqLd;
        end
        if (!block && (alu_valid || ld_valid)) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the single regfile write port between the ALU and load-unit writeback paths.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flush,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              gnt_ld,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        gnt;
    logic              last_ld;
    logic              xfer;
    logic              sel_ld;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_rr_arb2 (
        .alu_valid (alu_valid),
        .ld_valid  (ld_valid),
        .last_ld   (last_ld),
        .block     (rst | flush),
        .gnt       (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign ld_ready  = gnt[REQ_LD];
    assign xfer      = |gnt;
    assign sel_ld    = gnt[REQ_LD];
    assign sel_addr  = sel_ld ? ld_addr : alu_addr;
    assign sel_data  = sel_ld ? ld_data : alu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            gnt_ld       <= 1'b0;
            conflict_cnt <= '0;
            last_ld      <= 1'b1;
        end else begin
            we <= 1'b0;
            if (xfer) begin
                last_ld <= sel_ld;
                // x0 is hardwired: accept the transfer but never drive the port.
                if (sel_addr != '0) begin
                    we     <= 1'b1;
                    waddr  <= sel_addr;
                    wdata  <= sel_data;
                    gnt_ld <= sel_ld;
                end
            end
            if (alu_valid && ld_valid && !flush && conflict_cnt != CntMax) begin
                conflict_cnt <= conflict_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference model predicts readies and port writes per cycle.
module tb_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        gnt_ld;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, flush;
    logic [4:0]  alu_addr, ld_addr;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, we, gnt_ld;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] conflict_cnt;
    logic        alu_ready_s, ld_ready_s, we_s, gnt_ld_s;
    logic [4:0]  waddr_s;
    logic [31:0] wdata_s;
    logic [3:0]  conflict_cnt_s;

    // Raw shadow of the write port, x0 included, so a stray x0 write is visible.
    logic [31:0] shadow [32] = '{default: 32'h0};

    wr_t         exp_q[$];
    logic        m_last_ld;
    logic [15:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_gnt_ld;

    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  ar, lr;
    logic        ea, el;
    wr_t         e;

    always #5 clk = ~clk;

    always @(posedge clk) if (we) shadow[waddr] <= wdata;

    wb_arbiter u_dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .flush(flush), .we(we), .waddr(waddr), .wdata(wdata), .gnt_ld(gnt_ld),
        .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready_s), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready_s), .ld_addr(ld_addr), .ld_data(ld_data),
        .flush(flush), .we(we_s), .waddr(waddr_s), .wdata(wdata_s), .gnt_ld(gnt_ld_s),
        .conflict_cnt(conflict_cnt_s)
    );

    // Called just after a rising edge: samples readies mid-cycle, advances the model,
    // pushes the expected port state for the next cycle, returns just after the next edge.
    task automatic drive_cycle(output logic [1:0] o_ar, output logic [1:0] o_lr,
                               output logic o_ea, output logic o_el);
        wr_t         x;
        logic        both;
        logic [4:0]  a;
        logic [31:0] d;
        #4;
        o_ar = {alu_ready_s, alu_ready};
        o_lr = {ld_ready_s, ld_ready};
        both = alu_valid && ld_valid;
        o_ea = 1'b0;
        o_el = 1'b0;
        if (!rst && !flush) begin
            if (both) begin
                o_ea = m_last_ld;
                o_el = !m_last_ld;
            end else begin
                o_ea = alu_valid;
                o_el = ld_valid;
            end
        end
        x.we = 1'b0;
        if (rst) begin
            m_last_ld = 1'b1;
            m_cnt     = '0;
            m_cnt4    = '0;
            m_waddr   = '0;
            m_wdata   = '0;
            m_gnt_ld  = 1'b0;
        end else begin
            if (o_ea || o_el) begin
                m_last_ld = o_el;
                a = o_el ? ld_addr : alu_addr;
                d = o_el ? ld_data : alu_data;
                if (a != 5'd0) begin
                    m_waddr  = a;
                    m_wdata  = d;
                    m_gnt_ld = o_el;
                    x.we     = 1'b1;
                end
            end
            if (both && !flush) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
            end
        end
        x.waddr  = m_waddr;
        x.wdata  = m_wdata;
        x.gnt_ld = m_gnt_ld;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        flush = 1'b0;
        drive_cycle(ar, lr, ea, el);
        e = exp_q.pop_front();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        ld_valid  = 1'b1; ld_addr  = 5'd4; ld_data  = 32'h44;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            drive_cycle(ar, lr, ea, el);
            n_vec++;
            if (ar !== {2{ea}} || lr !== {2{el}}) begin
                n_err++;
                $display("FAIL reset ready[%0d]: alu=%b ld=%b want %b %b", i, ar, lr, ea, el);
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({we, waddr, wdata, gnt_ld} !== e || {we_s, waddr_s, wdata_s, gnt_ld_s} !== e) begin
                n_err++;
                $display("FAIL reset port[%0d]: got %h want %h", i, {we, waddr, wdata, gnt_ld}, e);
            end
            n_vec++;
            if (conflict_cnt !== m_cnt || conflict_cnt_s !== m_cnt4) begin
                n_err++;
                $display("FAIL reset cnt[%0d]: got %0d/%0d want %0d/%0d",
                         i, conflict_cnt, conflict_cnt_s, m_cnt, m_cnt4);
            end
        end
        n_vec++;
        if (ar[0] !== 1'b1 || lr[0] !== 1'b0 || gnt_ld !== 1'b0) begin
            n_err++;
            $display("FAIL reset first_conflict: alu_ready=%b ld_ready=%b gnt_ld=%b want 1 0 0",
                     ar[0], lr[0], gnt_ld);
        end
    endtask

    task automatic test_single();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        ld_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(ar, lr, ea, el);
            n_vec++;
            if (ar !== {2{ea}} || lr !== {2{el}}) begin
                n_err++;
                $display("FAIL single ready[%0d]: alu=%b ld=%b want %b %b", i, ar, lr, ea, el);
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({we, waddr, wdata, gnt_ld} !== e) begin
                n_err++;
                $display("FAIL single port[%0d]: got %h want %h", i, {we, waddr, wdata, gnt_ld}, e);
            end
            if (i == 0) begin
                n_vec++;
                if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF || gnt_ld !== 1'b0) begin
                    n_err++;
                    $display("FAIL single write: we=%b waddr=%0d wdata=%h gnt_ld=%b want 1 5 deadbeef 0",
                             we, waddr, wdata, gnt_ld);
                end
            end
            alu_valid = 1'b0;
        end
        n_vec++;
        if (shadow[5] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single regfile x5: got %h want deadbeef", shadow[5]);
        end
    endtask

    task automatic test_alternation();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        ld_valid  = 1'b1; ld_addr  = 5'd2; ld_data  = 32'h22;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                alu_valid = 1'b0;
                ld_valid = 1'b0;
            end
            drive_cycle(ar, lr, ea, el);
            n_vec++;
            if (ar !== {2{ea}} || lr !== {2{el}}) begin
                n_err++;
                $display("FAIL alt ready[%0d]: alu=%b ld=%b want %b %b", i, ar, lr, ea, el);
            end
            if (i < 4) begin
                n_vec++;
                if (lr[0] !== ((i % 2) == 1) || ar[0] !== ((i % 2) == 0)) begin
                    n_err++;
                    $display("FAIL alt order[%0d]: alu=%b ld=%b", i, ar[0], lr[0]);
                end
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({we, waddr, wdata, gnt_ld} !== e || conflict_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL alt port[%0d]: got %h cnt %0d want %h cnt %0d",
                         i, {we, waddr, wdata, gnt_ld}, conflict_cnt, e, m_cnt);
            end
        end
        n_vec++;
        if (conflict_cnt !== 16'd4) begin
            n_err++;
            $display("FAIL alt count: got %0d want 4", conflict_cnt);
        end
    endtask

    task automatic test_x0();
        do_reset();
        alu_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(ar, lr, ea, el);
            n_vec++;
            if (ar !== {2{ea}} || lr !== {2{el}}) begin
                n_err++;
                $display("FAIL x0 ready[%0d]: alu=%b ld=%b want %b %b", i, ar, lr, ea, el);
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({we, waddr, wdata, gnt_ld} !== e || we !== 1'b0) begin
                n_err++;
                $display("FAIL x0 port[%0d]: got %h want %h", i, {we, waddr, wdata, gnt_ld}, e);
            end
            ld_valid = 1'b0;
        end
        n_vec++;
        if (shadow[0] !== 32'h0) begin
            n_err++;
            $display("FAIL x0 regfile: got %h want 0", shadow[0]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                flush = 1'b1;
                ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 32'h88;
                #1;
                n_vec++;
                if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h77) begin
                    n_err++;
                    $display("FAIL flush keeps_write: we=%b waddr=%0d wdata=%h want 1 7 77",
                             we, waddr, wdata);
                end
            end
            if (i == 2) begin
                flush = 1'b0;
                alu_valid = 1'b0;
                ld_valid = 1'b0;
            end
            drive_cycle(ar, lr, ea, el);
            n_vec++;
            if (ar !== {2{ea}} || lr !== {2{el}}) begin
                n_err++;
                $display("FAIL flush ready[%0d]: alu=%b ld=%b want %b %b", i, ar, lr, ea, el);
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({we, waddr, wdata, gnt_ld} !== e || conflict_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL flush port[%0d]: got %h cnt %0d want %h cnt %0d",
                         i, {we, waddr, wdata, gnt_ld}, conflict_cnt, e, m_cnt);
            end
        end
        n_vec++;
        if (conflict_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL flush count: got %0d want 0", conflict_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0;
        ld_valid  = 1'b1; ld_addr  = 5'd11; ld_data  = 32'hB0;
        for (int i = 0; i < 20; i++) begin
            alu_data = 32'hA0 + i;
            ld_data  = 32'hB0 + i;
            drive_cycle(ar, lr, ea, el);
            n_vec++;
            if (ar !== {2{ea}} || lr !== {2{el}}) begin
                n_err++;
                $display("FAIL sat ready[%0d]: alu=%b ld=%b want %b %b", i, ar, lr, ea, el);
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({we_s, waddr_s, wdata_s, gnt_ld_s} !== e || conflict_cnt_s !== m_cnt4) begin
                n_err++;
                $display("FAIL sat cycle[%0d]: got %h cnt %0d want %h cnt %0d",
                         i, {we_s, waddr_s, wdata_s, gnt_ld_s}, conflict_cnt_s, e, m_cnt4);
            end
        end
        n_vec++;
        if (conflict_cnt_s !== 4'd15 || conflict_cnt !== 16'd20) begin
            n_err++;
            $display("FAIL sat final: got %0d/%0d want 15/20", conflict_cnt_s, conflict_cnt);
        end
        alu_valid = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0000000A;
        ld_valid  = 1'b1; ld_addr  = 5'd9; ld_data  = 32'h0000000B;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                alu_valid = 1'b0;
                ld_valid = 1'b0;
            end
            drive_cycle(ar, lr, ea, el);
            n_vec++;
            if (ar !== {2{ea}} || lr !== {2{el}}) begin
                n_err++;
                $display("FAIL b2b ready[%0d]: alu=%b ld=%b want %b %b", i, ar, lr, ea, el);
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({we, waddr, wdata, gnt_ld} !== e) begin
                n_err++;
                $display("FAIL b2b port[%0d]: got %h want %h", i, {we, waddr, wdata, gnt_ld}, e);
            end
        end
        n_vec++;
        if (shadow[9] !== 32'h0000000B) begin
            n_err++;
            $display("FAIL b2b regfile x9: got %h want 0000000b", shadow[9]);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
        m_last_ld = 1'b1; m_cnt = '0; m_cnt4 = '0;
        m_waddr = '0; m_wdata = '0; m_gnt_ld = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternation();
        test_x0();
        test_flush();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: ADDR_W, 5, register address width.
REQ-002 Parameter: DATA_W, 32, register data width.
REQ-003 Parameter: CNT_W, 16, conflict counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alu_valid / alu_ready  input / output  1 each  ALU writeback request / accept.
REQ-007 alu_addr, alu_data  input  ADDR_W, DATA_W  ALU destination register and value.
REQ-008 ld_valid / ld_ready  input / output  1 each  load-unit writeback request / accept.
REQ-009 ld_addr, ld_data  input  ADDR_W, DATA_W  load destination register and value.
REQ-010 flush  input  1  pipeline flush; suppresses new grants this cycle.
REQ-011 we, waddr, wdata  output  1, ADDR_W, DATA_W  registered write port driving regfile we/waddr/wdata.
REQ-012 gnt_ld  output  1  registered; 1 = current write came from load unit.
REQ-013 conflict_cnt  output  CNT_W  count of cycles both requesters were valid.

Function
REQ-014 Block SHALL share the single regfile write port between ALU and load requesters.
REQ-015 Transfer SHALL occur on a requester in a cycle where its valid and ready are both 1.
REQ-016 ready SHALL be combinational from valid, flush and priority pointer; valid SHALL NOT depend on ready.
REQ-017 At most one ready SHALL be 1 per cycle; with flush=1 both ready SHALL be 0.
REQ-018 Only one valid: that requester SHALL get ready=1.
REQ-019 Both valid: requester not granted most recently (1-bit pointer last_ld) SHALL get ready=1.
REQ-020 last_ld SHALL update only on a transfer (1 after load transfer, 0 after ALU transfer).
REQ-021 Un-granted requester SHALL hold valid/addr/data stable until accepted; block holds no buffer.
REQ-022 Latency: transfer in cycle N SHALL produce we=1, waddr, wdata, gnt_ld on outputs in cycle N+1, for exactly one cycle.
REQ-023 Transfer with addr=0 SHALL complete normally (ready=1, last_ld updates) but SHALL produce we=0 in N+1; waddr/wdata SHALL hold prior values.
REQ-024 No transfer in cycle N: we=0 in N+1; waddr, wdata, gnt_ld SHALL hold prior values.
REQ-025 flush=1 SHALL not cancel a write already registered on the outputs.
REQ-026 conflict_cnt SHALL increment when alu_valid=1 and ld_valid=1 and flush=0, saturating at 2^CNT_W-1 (no wrap).
REQ-027 Same-address writes from both requesters in consecutive cycles SHALL appear on the port in grant order; the later one wins in the regfile.

Reset
REQ-028 On rst=1 at a clock edge: we=0, waddr=0, wdata=0, gnt_ld=0, conflict_cnt=0, last_ld=1 (ALU wins first conflict).
REQ-029 While rst=1, alu_ready=0 and ld_ready=0; no transfer SHALL be counted or granted.
REQ-030 rst asserted mid-operation SHALL discard any write scheduled for the next cycle (we=0 after edge).

Structure
REQ-031 ADDR_W, DATA_W defaults and requester-index constants (REQ_ALU=0, REQ_LD=1) SHALL live in the shared core package used by regfile.
REQ-032 The two-way round-robin grant logic (valid pair, pointer, flush -> one-hot grant) SHALL be a sub-module rr_arb2; output registers and counter stay in wb_arbiter.

Verification
REQ-033 Reset: hold rst 2 cycles with both valid=1 -> both ready=0, we=0, conflict_cnt=0; first conflict after release grants ALU.
REQ-034 Single requester: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF one cycle -> next cycle we=1, waddr=5, wdata=0xDEADBEEF, gnt_ld=0; regfile rdata of x5 reads 0xDEADBEEF afterwards.
REQ-035 Conflict alternation: both valid held 4 cycles (ALU x1=0x11, load x2=0x22, each dropped after accept and re-raised) -> grants ALU, LD, ALU, LD; conflict_cnt=4 only for cycles with both valid.
REQ-036 x0 write: ld_valid=1, ld_addr=0, ld_data=0xFFFFFFFF -> ld_ready=1, next cycle we=0; regfile x0 still reads 0.
REQ-037 Flush: both valid with flush=1 for 1 cycle -> both ready=0, no we next cycle, conflict_cnt unchanged; a write registered before flush still appears with we=1.
REQ-038 Saturation: CNT_W=4, both valid with flush=0 for 20 cycles -> conflict_cnt stops at 15.
